// File: rtl/muxn_pipe_if.sv
// muxn_pipe_if: bus bundle for the muxn_pipe registered N:1 selector.
// The master side drives channel data, select and pipeline control; the
// slave side (the selector) drives the registered outputs.
// Configuration macro MUXN_PIPE_SEL_CHECK_EN adds the sticky sel_err flag.
interface muxn_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               stall;
  logic               flush;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic [SEL_W-1:0]   out_sel;
`ifdef MUXN_PIPE_SEL_CHECK_EN
  logic               sel_err;

  modport master (
    output in_bus, sel, in_valid, stall, flush,
    input  out, out_valid, out_sel, sel_err
  );

  modport slave (
    input  in_bus, sel, in_valid, stall, flush,
    output out, out_valid, out_sel, sel_err
  );
`else
  modport master (
    output in_bus, sel, in_valid, stall, flush,
    input  out, out_valid, out_sel
  );

  modport slave (
    input  in_bus, sel, in_valid, stall, flush,
    output out, out_valid, out_sel
  );
`endif
endinterface

// File: rtl/muxn_pipe.sv
// muxn_pipe: parametrised N-input, WIDTH-bit selector with a registered
// output stage, used at pipeline-register boundaries. Supports stall (hold),
// flush (bubble), a valid bit and DEF_VAL for out-of-range selects.
// Configuration macro MUXN_PIPE_SEL_CHECK_EN enables the sticky sel_err
// monitor; without it the datapath is identical and no monitor exists.
module muxn_pipe #(
  parameter int               WIDTH   = 32,
  parameter int               N       = 4,
  parameter logic [WIDTH-1:0] DEF_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  muxn_pipe_if.slave  bus
);
  localparam int SEL_W = $clog2(N);
  // One extra bit so that N itself is representable when N = 2^SEL_W.
  localparam logic [SEL_W:0] N_CMP = (SEL_W + 1)'(N);

  logic             in_range;
  logic [WIDTH-1:0] nxt;

  logic [WIDTH-1:0] out_d, out_q;
  logic             out_valid_d, out_valid_q;
  logic [SEL_W-1:0] out_sel_d, out_sel_q;

  // Combinational N:1 pick; out-of-range selects fall back to DEF_VAL.
  always_comb begin
    in_range = ({1'b0, bus.sel} < N_CMP);
    nxt      = DEF_VAL;
    if (in_range) begin
      for (int i = 0; i < N; i++) begin
        if (bus.sel == SEL_W'(i)) begin
          nxt = bus.in_bus[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Next-state for the output stage: flush beats stall, stall holds, else load.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    if (bus.flush) begin
      out_d       = DEF_VAL;
      out_valid_d = 1'b0;
      out_sel_d   = '0;
    end else if (!bus.stall) begin
      out_d       = nxt;
      out_valid_d = bus.in_valid;
      out_sel_d   = bus.sel;
    end
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= DEF_VAL;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;

`ifdef MUXN_PIPE_SEL_CHECK_EN
  logic sel_err_d, sel_err_q;

  // Sticky monitor: set by a real, accepted slot with an out-of-range select.
  always_comb begin
    sel_err_d = sel_err_q;
    if (!bus.flush && !bus.stall && bus.in_valid && !in_range) begin
      sel_err_d = 1'b1;
    end
  end

  // Monitor flop; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe: five muxn_pipe instances with different N/WIDTH/DEF_VAL
// share one stimulus stream. A behavioural model predicts each output after
// every edge and queues it; a monitor pops and compares on the falling edge.
// Honours MUXN_PIPE_SEL_CHECK_EN for the sel_err flag.
module tb_muxn_pipe;
  localparam int ND = 5;

  typedef struct {
    int          dut;
    logic [63:0] data;
    bit          valid;
    int          sel;
    bit          err;
  } exp_t;

  int          cfg_n   [ND] = '{4, 3, 2, 5, 16};
  int          cfg_w   [ND] = '{32, 16, 1, 64, 8};
  logic [63:0] cfg_def [ND] = '{64'h0, 64'hDEAD, 64'h1, 64'hA5A5_5A5A_0123_4567, 64'h7E};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          stall_v;
  logic          flush_v;
  logic          in_valid_v;
  logic [1023:0] pool;
  logic [3:0]    sel_v [ND];

  logic [63:0] m_out   [ND];
  bit          m_valid [ND];
  int          m_sel   [ND];
  bit          m_err   [ND];

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [63:0] act_out   [ND];
  logic        act_valid [ND];
  logic [3:0]  act_sel   [ND];

  muxn_pipe_if #(.WIDTH(32), .N(4))  if0 ();
  muxn_pipe_if #(.WIDTH(16), .N(3))  if1 ();
  muxn_pipe_if #(.WIDTH(1),  .N(2))  if2 ();
  muxn_pipe_if #(.WIDTH(64), .N(5))  if3 ();
  muxn_pipe_if #(.WIDTH(8),  .N(16)) if4 ();

  muxn_pipe #(.WIDTH(32), .N(4),  .DEF_VAL(32'h0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  muxn_pipe #(.WIDTH(16), .N(3),  .DEF_VAL(16'hDEAD))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  muxn_pipe #(.WIDTH(1),  .N(2),  .DEF_VAL(1'b1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  muxn_pipe #(.WIDTH(64), .N(5),  .DEF_VAL(64'hA5A5_5A5A_0123_4567))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  muxn_pipe #(.WIDTH(8),  .N(16), .DEF_VAL(8'h7E))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  assign if0.in_bus = pool[127:0];
  assign if1.in_bus = pool[47:0];
  assign if2.in_bus = pool[1:0];
  assign if3.in_bus = pool[319:0];
  assign if4.in_bus = pool[127:0];

  assign if0.sel = sel_v[0][1:0];
  assign if1.sel = sel_v[1][1:0];
  assign if2.sel = sel_v[2][0:0];
  assign if3.sel = sel_v[3][2:0];
  assign if4.sel = sel_v[4][3:0];

  assign if0.in_valid = in_valid_v;
  assign if1.in_valid = in_valid_v;
  assign if2.in_valid = in_valid_v;
  assign if3.in_valid = in_valid_v;
  assign if4.in_valid = in_valid_v;
  assign if0.stall = stall_v;
  assign if1.stall = stall_v;
  assign if2.stall = stall_v;
  assign if3.stall = stall_v;
  assign if4.stall = stall_v;
  assign if0.flush = flush_v;
  assign if1.flush = flush_v;
  assign if2.flush = flush_v;
  assign if3.flush = flush_v;
  assign if4.flush = flush_v;

  assign act_out[0] = 64'(if0.out);
  assign act_out[1] = 64'(if1.out);
  assign act_out[2] = 64'(if2.out);
  assign act_out[3] = 64'(if3.out);
  assign act_out[4] = 64'(if4.out);
  assign act_valid[0] = if0.out_valid;
  assign act_valid[1] = if1.out_valid;
  assign act_valid[2] = if2.out_valid;
  assign act_valid[3] = if3.out_valid;
  assign act_valid[4] = if4.out_valid;
  assign act_sel[0] = 4'(if0.out_sel);
  assign act_sel[1] = 4'(if1.out_sel);
  assign act_sel[2] = 4'(if2.out_sel);
  assign act_sel[3] = 4'(if3.out_sel);
  assign act_sel[4] = 4'(if4.out_sel);

`ifdef MUXN_PIPE_SEL_CHECK_EN
  logic act_err [ND];
  assign act_err[0] = if0.sel_err;
  assign act_err[1] = if1.sel_err;
  assign act_err[2] = if2.sel_err;
  assign act_err[3] = if3.sel_err;
  assign act_err[4] = if4.sel_err;
`endif

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: what each output stage must hold after this edge.
  task automatic updateModel();
    logic [63:0] mask;
    logic [63:0] chan;
    exp_t        e;
    for (int d = 0; d < ND; d++) begin
      mask = (cfg_w[d] == 64) ? '1 : ((64'd1 << cfg_w[d]) - 64'd1);
      if (!rst_n) begin
        m_out[d] = cfg_def[d]; m_valid[d] = 0; m_sel[d] = 0; m_err[d] = 0;
      end else if (flush_v) begin
        m_out[d] = cfg_def[d]; m_valid[d] = 0; m_sel[d] = 0;
      end else if (!stall_v) begin
        if (int'(sel_v[d]) < cfg_n[d]) begin
          chan     = 64'(pool >> (int'(sel_v[d]) * cfg_w[d]));
          m_out[d] = chan & mask;
        end else begin
          m_out[d] = cfg_def[d];
          if (in_valid_v) m_err[d] = 1;
        end
        m_valid[d] = in_valid_v;
        m_sel[d]   = int'(sel_v[d]);
      end
      e.dut = d; e.data = m_out[d]; e.valid = m_valid[d]; e.sel = m_sel[d]; e.err = m_err[d];
      sb_q.push_back(e);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit f, input bit v);
    rst_n      = r;
    stall_v    = s;
    flush_v    = f;
    in_valid_v = v;
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic randomizeInputs();
    for (int k = 0; k < 32; k++) pool[k*32 +: 32] = $urandom();
    for (int d = 0; d < ND; d++) begin
      sel_v[d] = 4'($urandom_range(0, (1 << $clog2(cfg_n[d])) - 1));
    end
  endtask

  // Monitor: every falling edge, compare each queued prediction with the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput($sformatf("d%0d out", e.dut), act_out[e.dut], e.data);
        checkOutput($sformatf("d%0d out_valid", e.dut), 64'(act_valid[e.dut]), 64'(e.valid));
        checkOutput($sformatf("d%0d out_sel", e.dut), 64'(act_sel[e.dut]), 64'(e.sel));
`ifdef MUXN_PIPE_SEL_CHECK_EN
        checkOutput($sformatf("d%0d sel_err", e.dut), 64'(act_err[e.dut]), 64'(e.err));
`endif
      end
    end
  end

  initial begin
    logic [31:0] chans [4];
    chans = '{32'h11, 32'h22, 32'h33, 32'h44};
    rst_n = 1'b0; stall_v = 1'b0; flush_v = 1'b0; in_valid_v = 1'b0;
    pool = '0;
    for (int k = 0; k < 4; k++) pool[k*32 +: 32] = chans[k];
    for (int d = 0; d < ND; d++) sel_v[d] = '0;

    // Reset for two cycles
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset out", act_out[0], 64'h0);
    checkOutput("reset out_valid", 64'(act_valid[0]), 64'h0);
    checkOutput("reset out_sel", 64'(act_sel[0]), 64'h0);
    checkOutput("reset def d1", act_out[1], 64'hDEAD);

    // Load sweep
    for (int k = 0; k < 4; k++) begin
      sel_v[0] = 4'(k);
      applyStimulus(1, 0, 0, 1);
      checkOutput($sformatf("sweep out sel%0d", k), act_out[0], 64'(chans[k]));
      checkOutput($sformatf("sweep out_sel %0d", k), 64'(act_sel[0]), 64'(k));
    end

    // Stall holds 0x22
    sel_v[0] = 4'd1;
    applyStimulus(1, 0, 0, 1);
    sel_v[0] = 4'd3; applyStimulus(1, 1, 0, 1);
    checkOutput("stall hold a", act_out[0], 64'h22);
    sel_v[0] = 4'd0; applyStimulus(1, 1, 0, 1);
    checkOutput("stall hold b", act_out[0], 64'h22);
    sel_v[0] = 4'd1; applyStimulus(1, 1, 0, 1);
    checkOutput("stall hold c", act_out[0], 64'h22);
    checkOutput("stall valid", 64'(act_valid[0]), 64'h1);
    sel_v[0] = 4'd2; applyStimulus(1, 0, 0, 1);
    checkOutput("stall release", act_out[0], 64'h33);

    // Flush beats stall, bubble then holds under stall
    applyStimulus(1, 1, 1, 1);
    checkOutput("flush out", act_out[0], 64'h0);
    checkOutput("flush out_valid", 64'(act_valid[0]), 64'h0);
    applyStimulus(1, 1, 0, 1);
    checkOutput("bubble hold", 64'(act_valid[0]), 64'h0);

    // Reset during stall
    sel_v[0] = 4'd3; applyStimulus(1, 0, 0, 1);
    checkOutput("load 44", act_out[0], 64'h44);
    applyStimulus(0, 1, 0, 1);
    checkOutput("reset mid-stall out", act_out[0], 64'h0);
    checkOutput("reset mid-stall out_sel", 64'(act_sel[0]), 64'h0);
    sel_v[0] = 4'd0; applyStimulus(1, 0, 0, 1);
    checkOutput("post-reset load", act_out[0], 64'h11);

    // Out-of-range select on N=3 instance
    sel_v[1] = 4'd3; applyStimulus(1, 0, 0, 1);
    checkOutput("oor out", act_out[1], 64'hDEAD);
    checkOutput("oor out_valid", 64'(act_valid[1]), 64'h1);
`ifdef MUXN_PIPE_SEL_CHECK_EN
    checkOutput("sel_err set", 64'(act_err[1]), 64'h1);
`endif
    applyStimulus(1, 0, 1, 1);
`ifdef MUXN_PIPE_SEL_CHECK_EN
    checkOutput("sel_err through flush", 64'(act_err[1]), 64'h1);
`endif
    applyStimulus(0, 0, 0, 0);
`ifdef MUXN_PIPE_SEL_CHECK_EN
    checkOutput("sel_err reset", 64'(act_err[1]), 64'h0);
`endif
    applyStimulus(1, 0, 0, 0);
    checkOutput("oor invalid out", act_out[1], 64'hDEAD);
    checkOutput("oor invalid valid", 64'(act_valid[1]), 64'h0);
`ifdef MUXN_PIPE_SEL_CHECK_EN
    checkOutput("sel_err invalid slot", 64'(act_err[1]), 64'h0);
`endif

    // Randomized run across all instances
    for (int c = 0; c < 400; c++) begin
      randomizeInputs();
      applyStimulus(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 20),
                    ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 75));
    end

    @(negedge clk);
    checkOutput("scoreboard drained", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/muxn_pipe.md
# muxn_pipe

Parametrised N-input, WIDTH-bit selector with a registered output stage. It is the successor of the fixed 4-way combinational operand selector. The block sits at pipeline-register boundaries in the datapath, for example the forwarding-operand select feeding the ID/EX register and the PC-source select feeding the IF register. It adds stall (hold), flush (bubble), a valid bit, out-of-range select handling and an optional select-error monitor.

## Interface
- WIDTH, 32, data width of each channel and of the output (1..64).
- N, 4, number of input channels (2..16).
- DEF_VAL, 0, value driven for an out-of-range select and loaded on flush; WIDTH bits wide.
- SEL_W is a derived localparam, not overridable: $clog2(N).
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_bus  input  N*WIDTH  flattened channels; channel i occupies in_bus[i*WIDTH +: WIDTH].
- sel  input  SEL_W  channel select.
- in_valid  input  1  the current in_bus/sel pair is a real instruction slot.
- stall  input  1  hold all output registers.
- flush  input  1  load a bubble.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  registered valid.
- out_sel  output  SEL_W  registered copy of the sel that produced out.
- sel_err  output  1  sticky out-of-range-select flag; present only with the configuration macro.

## Operation
- Combinational pick: nxt = channel[sel] when sel < N, otherwise DEF_VAL.
  - Out-of-range select is possible only when N is not a power of two.
- Register update at each rising edge, in priority order:
  1. rst_n = 0: out = DEF_VAL, out_valid = 0, out_sel = 0, sel_err = 0.
  2. flush = 1: out = DEF_VAL, out_valid = 0, out_sel = 0. Flush overrides stall.
  3. stall = 1: all registers hold.
  4. Otherwise: out = nxt, out_valid = in_valid, out_sel = sel.
- When in_valid = 0 and the block is not stalled or flushed, data still loads (out = nxt) with out_valid = 0. Downstream logic qualifies data with out_valid.
- No internal state beyond the output registers and sel_err. There is no state machine.
- Width rules:
  - No truncation or extension of data.
  - DEF_VAL is sized exactly to WIDTH.
  - The sel comparison against N is unsigned at SEL_W+1 bits, so N = 2^SEL_W compares correctly.
- Reset asserted mid-stall or mid-flush: reset wins, and outputs take their reset values at that edge.

## Timing
- Latency: 1 cycle from sel/in_bus/in_valid to out/out_valid/out_sel.
- Throughput: one new value per cycle while stall = 0.
- stall is level-sensitive. Outputs are frozen for every edge at which stall = 1 and flush = 0.
- flush affects only the edge at which it is sampled. The next unstalled edge loads normally.
- All outputs are driven directly from flops; no combinational path runs from inputs to outputs.
- The critical path is the N:1 select plus the out-of-range compare, ahead of the output flops.

## Configuration
- Macro: MUXN_PIPE_SEL_CHECK_EN.
- Defined:
  - sel_err sets on any edge where rst_n = 1, stall = 0, flush = 0, in_valid = 1 and sel >= N.
  - Once set, sel_err stays set until reset. Stall and flush do not clear it.
  - Invalid slots (in_valid = 0) never set it.
- Not defined:
  - The sel_err port is removed and no monitor logic is synthesised.
  - Out-of-range selects still yield DEF_VAL.
- In both builds the datapath behaviour is identical.

## Test plan
- Reset and load: hold rst_n = 0 for 2 cycles, confirm out = 0, out_valid = 0, out_sel = 0. Then, with N = 4, WIDTH = 32 and channels 0x11, 0x22, 0x33, 0x44, sweep sel = 0, 1, 2, 3 with in_valid = 1. Expect out = 0x11, 0x22, 0x33, 0x44 on the following edges, one cycle late, with out_sel tracking sel.
- Stall: load 0x22, then assert stall for 3 cycles while sel cycles through 3, 0, 1. Expect out = 0x22 and out_valid = 1 for all 3 cycles. Release stall and expect the current selection on the next edge.
- Flush priority: assert stall = 1 and flush = 1 together while out = 0x33. Expect out = DEF_VAL (0) and out_valid = 0 after that edge. With stall still 1 and flush 0, expect the bubble to hold.
- Out-of-range: set N = 3, DEF_VAL = 0xDEAD, sel = 3, in_valid = 1. Expect out = 0xDEAD and out_valid = 1.
  - With MUXN_PIPE_SEL_CHECK_EN defined, expect sel_err = 1 from the next edge, persisting through a later flush and clearing only after rst_n = 0.
  - Repeat with in_valid = 0 and expect sel_err to stay 0.
- Reset mid-operation: with stall = 1 and out = 0x44, drive rst_n = 0 for one edge. Expect all outputs at reset values on that edge, and normal loading once rst_n = 1.
- Parameter sweep: run the load test with N = 2, 5, 16 and WIDTH = 1, 64 using random channel data, and compare every cycle against a 1-cycle-delayed reference model.
